fifo_word_unpacker: RTL and testbench
=====================================

# fifo_word_unpacker

Downstream drain stage for `fifo_flush`: pops 32-bit words from the FIFO read port and emits them as eight 4-bit nibbles over a valid/ready stream, least-significant nibble first. It also sequences FIFO flushes on behalf of the control plane, driving the FIFO's flush input and reporting completion. It sits directly between the `fifo_flush` read side and the nibble-wide sink.

## Interface
Parameters:
- `WORD_W`, 32: FIFO word width; must be a multiple of `NIB_W`.
- `NIB_W`, 4: output nibble width.
- `CNT_W`, 16: width of the emitted-word counter.

Ports:
- `clock`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_data_avail_i`  in  1  FIFO holds at least one word.
- `fifo_empty_i`  in  1  FIFO empty.
- `fifo_rd_data_i`  in  `WORD_W`  FIFO read data, valid the cycle after the read strobe.
- `fifo_flush_done_i`  in  1  FIFO flush complete.
- `fifo_rd_valid_o`  out  1  single-cycle FIFO read strobe.
- `fifo_flush_o`  out  1  flush request to FIFO.
- `flush_req_i`  in  1  control-plane flush request (level).
- `flush_busy_o`  out  1  flush sequence in progress.
- `nib_valid_o`  out  1  nibble valid.
- `nib_ready_i`  in  1  sink ready.
- `nib_data_o`  out  `NIB_W`  nibble data.
- `nib_last_o`  out  1  last nibble of a word.
- `words_out_o`  out  `CNT_W`  count of fully emitted words.

## Operation
- **FSM states:** IDLE, READ, CAPTURE, SHIFT, FLUSH.
- **IDLE**
  - If `flush_req_i` is high, go to FLUSH. This takes priority over reading.
  - Otherwise, if `fifo_data_avail_i` is high and `fifo_empty_i` is low, go to READ.
- **READ**
  - `fifo_rd_valid_o` = 1 for exactly this cycle.
  - Always go to CAPTURE.
- **CAPTURE**
  - Register `fifo_rd_data_i` into the shift register.
  - Clear the nibble index to 0.
  - Go to SHIFT, or to FLUSH if `flush_req_i` is high (the captured word is discarded).
- **SHIFT**
  - Outputs: `nib_valid_o` = 1, `nib_data_o` = `word[NIB_W*idx +: NIB_W]`, `nib_last_o` = (idx == `WORD_W/NIB_W`-1).
  - A transfer occurs when `nib_valid_o` and `nib_ready_i` are both high; on each transfer idx increments.
  - On the last transfer:
    - `words_out_o` increments, wrapping modulo 2^`CNT_W`.
    - Next state is FLUSH if `flush_req_i`, else READ if data is available, else IDLE.
  - Abort rule: if `flush_req_i` rises before the last transfer, the remaining nibbles are dropped and the state goes to FLUSH. `nib_valid_o` falls the next cycle. This is the only case where valid drops without a transfer; `words_out_o` does not increment.
- **FLUSH**
  - `fifo_flush_o` = 1 and `flush_busy_o` = 1.
  - Stay in FLUSH until `fifo_flush_done_i` is sampled high, then go to IDLE.
  - `flush_req_i` is ignored while in FLUSH. A request still held on return to IDLE starts a new flush.
- **Handshake stability:** while `nib_valid_o` is high and `nib_ready_i` is low, `nib_data_o` and `nib_last_o` hold stable.
- **No FIFO underrun:** no read strobe is ever issued while `fifo_empty_i` is high.

## Timing
- **Reset:** while `reset` = 0, state = IDLE and every output = 0 (`words_out_o` = 0, shift register = 0). Asserting reset mid-word or mid-flush discards all progress immediately.
- **Latency:** from `fifo_data_avail_i` sampled high in IDLE, the read strobe appears 1 cycle later and the first nibble is valid 3 cycles later.
- **Throughput:** with the sink always ready, one word per `WORD_W/NIB_W` + 2 cycles (10 cycles at the defaults).
- **FLUSH exit:** the cycle after `fifo_flush_done_i` is sampled high, `fifo_flush_o` is 0 and the state is IDLE.
- **Simultaneous events:** `flush_req_i` and `fifo_data_avail_i` high together in IDLE → FLUSH. `flush_req_i` on the same cycle as the last nibble transfer → that word counts as emitted, then FLUSH.

## Structure
- Shared package `fifo_flush_pkg` holds the FSM state enum, `WORD_W`/`NIB_W` defaults, and the localparam `NIBS_PER_WORD` = `WORD_W/NIB_W`.
- No sub-module; the FSM, shift register, index counter and word counter form one module.

## Test plan
- **Single word:** FIFO supplies 0xDEADBEEF, sink always ready → nibbles F,E,E,B,D,A,E,D on consecutive cycles; `nib_last_o` high on D; `words_out_o` = 1.
- **Backpressure:** word 0x12345678 with `nib_ready_i` low for 3 cycles at idx 2 → `nib_data_o` holds 6 for those cycles; the full sequence 8,7,6,5,4,3,2,1 is intact.
- **Back-to-back:** two words 0x0000000A and 0x00000003 → a 2-cycle gap between the last nibble of word 0 and the first of word 1; `words_out_o` = 2.
- **Abort flush:** `flush_req_i` rises at idx 3 → `nib_valid_o` low next cycle; `fifo_flush_o` high until `fifo_flush_done_i` is seen; `words_out_o` unchanged; no read strobe during FLUSH.
- **Empty guard and idle flush:** `fifo_empty_i` high with `fifo_data_avail_i` low → no `fifo_rd_valid_o` ever. `flush_req_i` in IDLE → `flush_busy_o` high until done + 1 cycle.
- **Reset mid-word:** `reset` low at idx 5 → all outputs 0 asynchronously; after release the FSM is in IDLE and the next word starts at idx 0.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
// fifo_flush_pkg: shared definitions for the fifo_flush drain path.
//   state_t        FSM states of the word unpacker
//   DEF_WORD_W     default FIFO word width
//   DEF_NIB_W      default output nibble width
//   NIBS_PER_WORD  nibbles per word at the default widths
package fifo_flush_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SHIFT,
        FLUSH
    } state_t;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NIB_W     = 4;
    localparam int NIBS_PER_WORD = DEF_WORD_W / DEF_NIB_W;

endpackage

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: drains 32-bit words from the fifo_flush read port and
// emits them as a valid/ready nibble stream, least-significant nibble first,
// while also sequencing FIFO flushes for the control plane.
//   clock, reset        clock and asynchronous active-low reset
//   fifo_data_avail_i   FIFO holds at least one word
//   fifo_empty_i        FIFO empty
//   fifo_rd_data_i      FIFO read data, valid the cycle after the strobe
//   fifo_flush_done_i   FIFO flush complete
//   fifo_rd_valid_o     single-cycle FIFO read strobe
//   fifo_flush_o        flush request to the FIFO
//   flush_req_i         control-plane flush request (level)
//   flush_busy_o        flush sequence in progress
//   nib_valid_o/nib_ready_i/nib_data_o/nib_last_o  nibble stream
//   words_out_o         count of fully emitted words (wraps)
module fifo_word_unpacker
    import fifo_flush_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int NIB_W  = DEF_NIB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_data_avail_i,
    input  logic              fifo_empty_i,
    input  logic [WORD_W-1:0] fifo_rd_data_i,
    input  logic              fifo_flush_done_i,
    output logic              fifo_rd_valid_o,
    output logic              fifo_flush_o,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              nib_valid_o,
    input  logic              nib_ready_i,
    output logic [NIB_W-1:0]  nib_data_o,
    output logic              nib_last_o,
    output logic [CNT_W-1:0]  words_out_o
);

    localparam int NIBS  = WORD_W / NIB_W;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  words;
    logic              can_read;
    logic              at_last;
    logic              xfer;
    logic              last_xfer;

    // A read is only started when the FIFO both reports data and is not
    // empty, so no strobe can ever reach an empty FIFO.
    always_comb begin
        can_read  = fifo_data_avail_i && !fifo_empty_i;
        at_last   = idx == IDX_W'(NIBS - 1);
        xfer      = (state == SHIFT) && nib_ready_i;
        last_xfer = xfer && at_last;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = flush_req_i ? FLUSH : (can_read ? READ : IDLE);
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = flush_req_i ? FLUSH : SHIFT;
            // A flush request wins over the rest of the word; if it lands on
            // the last transfer the word has already been counted.
            SHIFT:   state_nx = flush_req_i ? FLUSH :
                                !last_xfer  ? SHIFT :
                                can_read    ? READ  : IDLE;
            FLUSH:   state_nx = fifo_flush_done_i ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            words <= '0;
        end else begin
            state <= state_nx;
            if (state == CAPTURE) begin
                word <= fifo_rd_data_i;
                idx  <= '0;
            end else if (xfer) begin
                idx <= idx + IDX_W'(1);
            end
            if (last_xfer)
                words <= words + CNT_W'(1);
        end
    end

    assign fifo_rd_valid_o = state == READ;
    assign fifo_flush_o    = state == FLUSH;
    assign flush_busy_o    = state == FLUSH;
    assign nib_valid_o     = state == SHIFT;
    assign nib_data_o      = nib_valid_o ? word[idx*NIB_W +: NIB_W] : '0;
    assign nib_last_o      = nib_valid_o && at_last;
    assign words_out_o     = words;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb_fifo_word_unpacker: randomized self-checking bench for fifo_word_unpacker
// with a queue-based FIFO model and a word-level reference for the nibble stream.
module tb_fifo_word_unpacker;

    logic        clock = 0;
    logic        reset = 0;
    logic        fifo_data_avail_i = 0;
    logic        fifo_empty_i = 1;
    logic [31:0] fifo_rd_data_i = 0;
    logic        fifo_flush_done_i = 0;
    logic        fifo_rd_valid_o;
    logic        fifo_flush_o;
    logic        flush_req_i = 0;
    logic        flush_busy_o;
    logic        nib_valid_o;
    logic        nib_ready_i = 0;
    logic [3:0]  nib_data_o;
    logic        nib_last_o;
    logic [15:0] words_out_o;

    int checks = 0;
    int errors = 0;
    int exp_words = 0;
    int strobes = 0;
    int underruns = 0;
    bit override = 0;
    logic [31:0] fifo_q[$];

    fifo_word_unpacker dut (
        .clock(clock),
        .reset(reset),
        .fifo_data_avail_i(fifo_data_avail_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_flush_done_i(fifo_flush_done_i),
        .fifo_rd_valid_o(fifo_rd_valid_o),
        .fifo_flush_o(fifo_flush_o),
        .flush_req_i(flush_req_i),
        .flush_busy_o(flush_busy_o),
        .nib_valid_o(nib_valid_o),
        .nib_ready_i(nib_ready_i),
        .nib_data_o(nib_data_o),
        .nib_last_o(nib_last_o),
        .words_out_o(words_out_o)
    );

    initial forever #5 clock = ~clock;

    // FIFO model: a strobe seen in a cycle pops the head onto the read data
    // bus, which the DUT samples at the end of the following cycle.
    initial forever begin
        @(negedge clock);
        if (fifo_rd_valid_o) begin
            strobes++;
            if (fifo_q.size() == 0) begin
                underruns++;
                fifo_rd_data_i = $urandom;
            end else begin
                fifo_rd_data_i = fifo_q.pop_front();
            end
        end
        if (!override) begin
            fifo_data_avail_i = fifo_q.size() != 0;
            fifo_empty_i      = fifo_q.size() == 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_data_avail_i = 1;
        fifo_empty_i = 0;
    endtask

    task automatic clear_fifo;
        fifo_q.delete();
        fifo_data_avail_i = 0;
        fifo_empty_i = 1;
    endtask

    // Sink: accepts n_xfer nibbles, optionally stalling at one index or
    // randomizing ready; rebuilds the word from the accepted nibbles.
    task automatic collect(input int n_xfer, input int stall_at, input int stall_len, input bit rnd,
                           output logic [31:0] got, output logic [7:0] lasts, output bit hold_ok,
                           output int first, output logic [3:0] stall_val, output bit timeout);
        int n = 0;
        int st = 0;
        int guard = 0;
        bit holding = 0;
        logic [3:0] held = 0;
        got = 0; lasts = 0; hold_ok = 1; first = 0; stall_val = 0; timeout = 0;
        while (n < n_xfer) begin
            @(negedge clock);
            guard++;
            if (guard > 300) begin
                timeout = 1;
                break;
            end
            if (first == 0 && nib_valid_o) first = guard;
            if (nib_valid_o) begin
                if (holding && nib_data_o !== held) hold_ok = 0;
                if (n == stall_at && st < stall_len) begin
                    nib_ready_i = 0;
                    st++;
                    stall_val = nib_data_o;
                end else begin
                    nib_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (nib_ready_i) begin
                    got[4*n +: 4] = nib_data_o;
                    lasts[n] = nib_last_o;
                    n++;
                    holding = 0;
                end else begin
                    holding = 1;
                    held = nib_data_o;
                end
            end else begin
                nib_ready_i = 1;
            end
        end
    endtask

    task automatic test_reset;
        logic [24:0] outs;
        reset = 0;
        repeat (3) @(negedge clock);
        outs = {fifo_rd_valid_o, fifo_flush_o, flush_busy_o, nib_valid_o, nib_last_o, nib_data_o, words_out_o};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        reset = 1;
        @(negedge clock);
        outs = {fifo_rd_valid_o, fifo_flush_o, flush_busy_o, nib_valid_o, nib_last_o, nib_data_o, words_out_o};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL post_reset_idle got %h want 0", outs); end
    endtask

    task automatic test_single;
        logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        push(32'hDEADBEEF);
        @(negedge clock);
        checks++;
        if (fifo_rd_valid_o !== 1'b1) begin errors++; $display("FAIL single_strobe got %b want 1", fifo_rd_valid_o); end
        collect(8, -1, 0, 0, got, lasts, hold, first, sv, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %b want 0", to); end
        checks++;
        if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL single_word got %h want deadbeef", got); end
        checks++;
        if (lasts !== 8'h80) begin errors++; $display("FAIL single_last got %h want 80", lasts); end
        checks++;
        if (first !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", first); end
        exp_words++;
        @(negedge clock);
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL single_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_backpressure;
        logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        logic [31:0] w = 32'h12345678;
        push(w);
        collect(8, 2, 3, 0, got, lasts, hold, first, sv, to);
        checks++;
        if (got !== w || to) begin errors++; $display("FAIL bp_word got %h want %h", got, w); end
        checks++;
        if (sv !== 4'((w >> 8) & 32'hF)) begin errors++; $display("FAIL bp_stall_data got %h want 6", sv); end
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL bp_hold got %b want 1", hold); end
        checks++;
        if (lasts !== 8'h80) begin errors++; $display("FAIL bp_last got %h want 80", lasts); end
        exp_words++;
        @(negedge clock);
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL bp_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] g0, g1; logic [7:0] l0, l1; bit h; int f0, f1; logic [3:0] sv; bit t0, t1;
        push(32'h0000000A);
        push(32'h00000003);
        collect(8, -1, 0, 0, g0, l0, h, f0, sv, t0);
        collect(8, -1, 0, 0, g1, l1, h, f1, sv, t1);
        checks++;
        if (g0 !== 32'h0000000A || t0) begin errors++; $display("FAIL b2b_word0 got %h want 0000000a", g0); end
        checks++;
        if (g1 !== 32'h00000003 || t1) begin errors++; $display("FAIL b2b_word1 got %h want 00000003", g1); end
        checks++;
        if (f1 - 1 !== 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", f1 - 1); end
        exp_words += 2;
        @(negedge clock);
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL b2b_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_random_stream;
        logic [31:0] ws[6]; logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        foreach (ws[i]) begin
            ws[i] = $urandom;
            push(ws[i]);
        end
        foreach (ws[i]) begin
            collect(8, -1, 0, 1, got, lasts, hold, first, sv, to);
            checks++;
            if (got !== ws[i] || lasts !== 8'h80 || !hold || to)
                begin errors++; $display("FAIL rand_word%0d got %h/%h want %h/80", i, got, lasts, ws[i]); end
        end
        exp_words += 6;
        @(negedge clock);
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL rand_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_abort_flush;
        logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        logic [31:0] w = $urandom;
        int s0;
        push(w);
        push($urandom);
        collect(3, -1, 0, 0, got, lasts, hold, first, sv, to);
        checks++;
        if (got[11:0] !== w[11:0] || to) begin errors++; $display("FAIL abort_prefix got %h want %h", got[11:0], w[11:0]); end
        @(negedge clock);
        checks++;
        if (nib_valid_o !== 1'b1 || nib_data_o !== w[15:12])
            begin errors++; $display("FAIL abort_idx3 got %b/%h want 1/%h", nib_valid_o, nib_data_o, w[15:12]); end
        flush_req_i = 1;
        s0 = strobes;
        @(negedge clock);
        flush_req_i = 0;
        checks++;
        if (nib_valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid_drop got %b want 0", nib_valid_o); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fifo_flush_o !== 1'b1 || flush_busy_o !== 1'b1)
                begin errors++; $display("FAIL abort_flush_hold%0d got %b%b want 11", i, fifo_flush_o, flush_busy_o); end
            @(negedge clock);
        end
        fifo_flush_done_i = 1;
        clear_fifo();
        @(negedge clock);
        fifo_flush_done_i = 0;
        checks++;
        if (fifo_flush_o !== 1'b0 || flush_busy_o !== 1'b0)
            begin errors++; $display("FAIL abort_flush_exit got %b%b want 00", fifo_flush_o, flush_busy_o); end
        checks++;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL abort_no_read got %0d want 0", strobes - s0); end
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL abort_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_flush_on_last;
        logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        logic [31:0] w = $urandom;
        push(w);
        collect(7, -1, 0, 0, got, lasts, hold, first, sv, to);
        @(negedge clock);
        checks++;
        if (nib_last_o !== 1'b1 || nib_data_o !== w[31:28] || to)
            begin errors++; $display("FAIL lastflush_nib got %b/%h want 1/%h", nib_last_o, nib_data_o, w[31:28]); end
        flush_req_i = 1;
        nib_ready_i = 1;
        exp_words++;
        @(negedge clock);
        flush_req_i = 0;
        checks++;
        if (fifo_flush_o !== 1'b1 || words_out_o !== 16'(exp_words))
            begin errors++; $display("FAIL lastflush_state got %b/%0d want 1/%0d", fifo_flush_o, words_out_o, exp_words); end
        fifo_flush_done_i = 1;
        @(negedge clock);
        fifo_flush_done_i = 0;
        checks++;
        if (flush_busy_o !== 1'b0) begin errors++; $display("FAIL lastflush_exit got %b want 0", flush_busy_o); end
    endtask

    task automatic test_empty_guard;
        int s0 = strobes;
        override = 1;
        fifo_data_avail_i = 0;
        fifo_empty_i = 1;
        repeat (10) @(negedge clock);
        fifo_data_avail_i = 1;
        repeat (10) @(negedge clock);
        checks++;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL empty_guard got %0d strobes want 0", strobes - s0); end
        checks++;
        if (nib_valid_o !== 1'b0) begin errors++; $display("FAIL empty_guard_valid got %b want 0", nib_valid_o); end
        override = 0;
        fifo_data_avail_i = 0;
    endtask

    task automatic test_idle_flush;
        @(negedge clock);
        flush_req_i = 1;
        push($urandom);
        @(negedge clock);
        checks++;
        if (fifo_flush_o !== 1'b1 || fifo_rd_valid_o !== 1'b0)
            begin errors++; $display("FAIL idle_flush_priority got %b%b want 10", fifo_flush_o, fifo_rd_valid_o); end
        repeat (3) @(negedge clock);
        checks++;
        if (flush_busy_o !== 1'b1) begin errors++; $display("FAIL idle_flush_busy got %b want 1", flush_busy_o); end
        fifo_flush_done_i = 1;
        clear_fifo();
        @(negedge clock);
        fifo_flush_done_i = 0;
        checks++;
        if (flush_busy_o !== 1'b0) begin errors++; $display("FAIL idle_flush_exit got %b want 0", flush_busy_o); end
        @(negedge clock);
        checks++;
        if (flush_busy_o !== 1'b1) begin errors++; $display("FAIL idle_flush_rearm got %b want 1", flush_busy_o); end
        flush_req_i = 0;
        fifo_flush_done_i = 1;
        @(negedge clock);
        fifo_flush_done_i = 0;
        checks++;
        if (flush_busy_o !== 1'b0 || fifo_flush_o !== 1'b0)
            begin errors++; $display("FAIL idle_flush_final got %b%b want 00", flush_busy_o, fifo_flush_o); end
    endtask

    task automatic test_reset_mid_word;
        logic [31:0] got; logic [7:0] lasts; bit hold; int first; logic [3:0] sv; bit to;
        logic [31:0] w = $urandom;
        logic [31:0] w2 = $urandom;
        logic [24:0] outs;
        push(w);
        collect(5, -1, 0, 0, got, lasts, hold, first, sv, to);
        @(negedge clock);
        nib_ready_i = 0;
        checks++;
        if (nib_data_o !== w[23:20] || to) begin errors++; $display("FAIL rst_mid_idx5 got %h want %h", nib_data_o, w[23:20]); end
        #2 reset = 0;
        #1;
        outs = {fifo_rd_valid_o, fifo_flush_o, flush_busy_o, nib_valid_o, nib_last_o, nib_data_o, words_out_o};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rst_mid_async got %h want 0", outs); end
        clear_fifo();
        exp_words = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        push(w2);
        collect(8, -1, 0, 0, got, lasts, hold, first, sv, to);
        checks++;
        if (got !== w2 || lasts !== 8'h80 || to) begin errors++; $display("FAIL rst_mid_restart got %h/%h want %h/80", got, lasts, w2); end
        exp_words++;
        @(negedge clock);
        checks++;
        if (words_out_o !== 16'(exp_words)) begin errors++; $display("FAIL rst_mid_count got %0d want %0d", words_out_o, exp_words); end
    endtask

    task automatic test_no_underrun;
        checks++;
        if (underruns !== 0) begin errors++; $display("FAIL underrun got %0d want 0", underruns); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_abort_flush();
        test_flush_on_last();
        test_empty_guard();
        test_idle_flush();
        test_reset_mid_word();
        test_no_underrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
